// File: rtl/cam_stream_pack_if.sv
// Camera pixel bus in, framed pixel stream out. The master modport is the packer side;
// the slave modport is the camera/filter environment around it.
interface cam_stream_pack_if #(
    parameter int unsigned DW = 8
);
    logic          cam_vsync;
    logic          cam_href;
    logic [DW-1:0] cam_data;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_sop;
    logic          dout_eop;
    logic          frame_err;

    modport master (
        input  cam_vsync,
        input  cam_href,
        input  cam_data,
        output dout,
        output dout_vld,
        output dout_sop,
        output dout_eop,
        output frame_err
    );

    modport slave (
        output cam_vsync,
        output cam_href,
        output cam_data,
        input  dout,
        input  dout_vld,
        input  dout_sop,
        input  dout_eop,
        input  frame_err
    );
endinterface

// File: rtl/cam_stream_pack.sv
// Packetises a vsync/href camera bus into a COL*ROW pixel stream with sop/eop framing,
// dropping overlong-line pixels and pulsing frame_err on short lines or early vsync.
module cam_stream_pack #(
    parameter int unsigned COL = 640,
    parameter int unsigned ROW = 480,
    parameter int unsigned DW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    cam_stream_pack_if.master bus
);
    localparam int unsigned CW = $clog2(COL);
    localparam int unsigned RW = $clog2(ROW);
    localparam logic [CW-1:0] ColLast = CW'(COL - 1);
    localparam logic [RW-1:0] RowLast = RW'(ROW - 1);

    typedef enum logic [1:0] {StIdle, StWaitVs, StActive} state_e;

    state_e        state_q, state_d;
    logic          vsync_ff;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          line_done_q, line_done_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          err_q, err_d;
    logic          vs_rise;
    logic          at_last;

    assign vs_rise = bus.cam_vsync & ~vsync_ff;
    assign at_last = (col_q == ColLast) && (row_q == RowLast);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        line_done_d = line_done_q;
        dout_d      = dout_q;
        vld_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) state_d = StWaitVs;
            end
            StWaitVs: begin
                if (vs_rise) begin
                    state_d     = StActive;
                    col_d       = '0;
                    row_d       = '0;
                    line_done_d = 1'b0;
                end else if (!en) begin
                    state_d = StIdle;
                end
            end
            StActive: begin
                if (bus.cam_href && !line_done_q && at_last) begin
                    // Final pixel: a coincident vs_rise re-arms the next frame directly.
                    vld_d  = 1'b1;
                    dout_d = bus.cam_data;
                    eop_d  = 1'b1;
                    col_d  = '0;
                    row_d  = '0;
                    if (!en) begin
                        state_d = StIdle;
                    end else if (!vs_rise) begin
                        state_d = StWaitVs;
                    end
                end else if (vs_rise) begin
                    err_d       = 1'b1;
                    col_d       = '0;
                    row_d       = '0;
                    line_done_d = 1'b0;
                    if (bus.cam_href) begin
                        vld_d  = 1'b1;
                        dout_d = bus.cam_data;
                        sop_d  = 1'b1;
                        col_d  = CW'(1);
                    end
                end else if (bus.cam_href) begin
                    if (!line_done_q) begin
                        vld_d  = 1'b1;
                        dout_d = bus.cam_data;
                        sop_d  = (col_q == '0) && (row_q == '0);
                        if (col_q == ColLast) begin
                            col_d       = '0;
                            row_d       = row_q + RW'(1);
                            line_done_d = 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end else begin
                    line_done_d = 1'b0;
                    // href dropped part-way through a line.
                    if (col_q != '0) begin
                        err_d   = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = StWaitVs;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vsync_ff    <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            line_done_q <= 1'b0;
            dout_q      <= '0;
            vld_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_ff    <= bus.cam_vsync;
            col_q       <= col_d;
            row_q       <= row_d;
            line_done_q <= line_done_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = vld_q;
    assign bus.dout_sop  = sop_q;
    assign bus.dout_eop  = eop_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_cam_stream_pack.sv
// Directed bench for cam_stream_pack at COL=4, ROW=3, DW=8: clean frames, short/long lines,
// early vsync, eop+vsync, enable drop and asynchronous reset.
module tb_cam_stream_pack;
    logic clk;
    logic rst_n;
    logic en;

    cam_stream_pack_if #(.DW(8)) bus ();

    cam_stream_pack #(
        .COL(4),
        .ROW(3),
        .DW (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {vld, sop, eop, err, dout}
    logic [11:0] obs;
    assign obs = {bus.dout_vld, bus.dout_sop, bus.dout_eop, bus.frame_err, bus.dout};

    int          checks;
    int          passed;
    logic [7:0]  hold;
    logic [11:0] got[$];
    logic [11:0] want[$];

    function automatic logic [11:0] ev(input logic v, input logic s, input logic e,
                                       input logic r, input logic [7:0] d);
        return {v, s, e, r, d};
    endfunction

    // One cycle: drive at a falling edge, capture outputs at the next falling edge.
    task automatic cyc(input logic v, input logic h, input logic [7:0] d, input logic [11:0] w);
        bus.cam_vsync = v;
        bus.cam_href  = h;
        bus.cam_data  = d;
        @(negedge clk);
        got.push_back(obs);
        want.push_back(w);
    endtask

    // Three 4-pixel lines with 2-cycle gaps; data base..base+11.
    task automatic frame(input logic [7:0] base, input bit with_vs, input bit vs_on_eop,
                         input int drop_at);
        int         k;
        logic [7:0] d;
        if (with_vs) cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                k = r * 4 + c;
                d = base + 8'(k);
                cyc(vs_on_eop && (k == 11), 1'b1, d, ev(1, k == 0, k == 11, 0, d));
                hold = d;
                if (k == drop_at) en = 1'b0;
            end
            for (int g = 0; g < 2; g++) cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        en = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href = 1'b0;
        bus.cam_data = 8'h00;
        hold = 8'h00;
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 12'h000) $display("FAIL reset_hold got=%h want=000", obs);
        else passed++;
        rst_n = 1'b1;
        got.delete();
        want.delete();
        // en low: IDLE ignores vsync and href entirely.
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h00));
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h00));
        cyc(1'b0, 1'b1, 8'hA5, ev(0, 0, 0, 0, 8'h00));
        cyc(1'b0, 1'b1, 8'h5A, ev(0, 0, 0, 0, 8'h00));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h00));
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL reset_idle cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_full_frame;
        got.delete();
        want.delete();
        en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        // href before vsync is ignored in WAIT_VS.
        cyc(1'b0, 1'b1, 8'hEE, ev(0, 0, 0, 0, hold));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        frame(8'h01, 1'b1, 1'b0, -1);
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL full_frame cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_short_line;
        got.delete();
        want.delete();
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 8'h11 + 8'(c), ev(1, c == 0, 0, 0, 8'h11 + 8'(c)));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h14));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h14));
        cyc(1'b0, 1'b1, 8'h15, ev(1, 0, 0, 0, 8'h15));
        cyc(1'b0, 1'b1, 8'h16, ev(1, 0, 0, 0, 8'h16));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 1, 8'h16));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h16));
        // Rest of the aborted frame is dropped until the next vsync.
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 8'h17 + 8'(c), ev(0, 0, 0, 0, 8'h16));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h16));
        hold = 8'h16;
        frame(8'h21, 1'b1, 1'b0, -1);
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL short_line cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_long_line;
        got.delete();
        want.delete();
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 8'h31 + 8'(c), ev(1, c == 0, 0, 0, 8'h31 + 8'(c)));
        cyc(1'b0, 1'b1, 8'h35, ev(0, 0, 0, 0, 8'h34));
        cyc(1'b0, 1'b1, 8'h36, ev(0, 0, 0, 0, 8'h34));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h34));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h34));
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b1, 8'h37 + 8'(c), ev(1, 0, c == 7, 0, 8'h37 + 8'(c)));
            if (c == 3) begin
                cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h3A));
                cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h3A));
            end
        end
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h3E));
        hold = 8'h3E;
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL long_line cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_vs_abort;
        got.delete();
        want.delete();
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 8'h41 + 8'(c), ev(1, c == 0, 0, 0, 8'h41 + 8'(c)));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h44));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h44));
        cyc(1'b0, 1'b1, 8'h45, ev(1, 0, 0, 0, 8'h45));
        // Early vsync aborts but stays armed: the next pixel needs no further vsync.
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 1, 8'h45));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h45));
        hold = 8'h45;
        frame(8'h51, 1'b0, 1'b0, -1);
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL vs_abort cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        got.delete();
        want.delete();
        frame(8'h91, 1'b1, 1'b1, -1);
        frame(8'hA1, 1'b0, 1'b0, -1);
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL back_to_back cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_en_drop;
        got.delete();
        want.delete();
        frame(8'h61, 1'b1, 1'b0, 2);
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h6C));
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 8'h70 + 8'(c), ev(0, 0, 0, 0, 8'h6C));
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h6C));
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL en_drop cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        got.delete();
        want.delete();
        en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        cyc(1'b1, 1'b0, 8'h00, ev(0, 0, 0, 0, hold));
        cyc(1'b0, 1'b1, 8'h71, ev(1, 1, 0, 0, 8'h71));
        cyc(1'b0, 1'b1, 8'h72, ev(1, 0, 0, 0, 8'h72));
        bus.cam_data = 8'h73;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) $display("FAIL reset_mid_async got=%h want=000", obs);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.cam_href = 1'b0;
        hold = 8'h00;
        cyc(1'b0, 1'b0, 8'h00, ev(0, 0, 0, 0, 8'h00));
        frame(8'h81, 1'b1, 1'b0, -1);
        foreach (want[i]) begin
            checks++;
            if (got[i] !== want[i]) $display("FAIL reset_mid cyc%0d got=%h want=%h", i, got[i], want[i]);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_full_frame();
        test_short_line();
        test_long_line();
        test_vs_abort();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
